// File: rtl/pcs_sync_pkg.sv
// Shared sync-header constants, lock FSM state type and header classification
// for the 64b/66b receive block-sync monitor.
package pcs_sync_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic {
    TEST_SH,
    SLIP_WAIT
  } lock_state_t;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_ber_monitor.sv
// BER window monitor: counts invalid headers per timer window while locked and
// raises hi_ber when the count reaches BER_CNT_MAX within one window.
module pcs_ber_monitor #(
  parameter int unsigned BER_TIMER_CYCLES = 40283,
  parameter int unsigned BER_CNT_MAX      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       block_lock,
  input  logic       header_valid,
  input  logic       sh_invalid,
  output logic       hi_ber,
  output logic [7:0] ber_count
);

  localparam int unsigned TMR_W = (BER_TIMER_CYCLES > 1) ? $clog2(BER_TIMER_CYCLES) : 1;
  localparam int unsigned CNT_W = ($clog2(BER_CNT_MAX + 1) > 8) ? $clog2(BER_CNT_MAX + 1) : 8;

  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hit;
  logic             wrap;

  always_comb begin
    hit  = header_valid & sh_invalid;
    wrap = (timer == TMR_W'(BER_TIMER_CYCLES - 1));
    // A hit on the wrap cycle belongs to the window that is just starting
    if (wrap)
      cnt_nxt = hit ? CNT_W'(1) : '0;
    else if (hit && (cnt != '1))
      cnt_nxt = cnt + CNT_W'(1);
    else
      cnt_nxt = cnt;
  end

  always_ff @(posedge clk) begin
    if (reset || !block_lock) begin
      timer  <= '0;
      cnt    <= '0;
      hi_ber <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + TMR_W'(1);
      cnt   <= cnt_nxt;
      if (wrap)
        hi_ber <= (cnt >= CNT_W'(BER_CNT_MAX)) || (cnt_nxt >= CNT_W'(BER_CNT_MAX));
      else if (cnt_nxt >= CNT_W'(BER_CNT_MAX))
        hi_ber <= 1'b1;
    end
  end

  assign ber_count = (cnt > CNT_W'(255)) ? 8'hFF : cnt[7:0];

endmodule

// File: rtl/pcs_rx_sync_monitor.sv
// 64b/66b receive block lock, gearbox slip and BER monitor.
// Optional saturating statistics counters enabled by PCS_SYNC_STATS_EN.
module pcs_rx_sync_monitor #(
  parameter int unsigned SH_CNT_MAX       = 64,
  parameter int unsigned SH_INVALID_MAX   = 16,
  parameter int unsigned SLIP_WAIT_CYCLES = 32,
  parameter int unsigned BER_TIMER_CYCLES = 40283,
  parameter int unsigned BER_CNT_MAX      = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_header,
  input  logic        i_header_valid,
  input  logic        i_stats_clear,
  output logic        o_slip,
  output logic        o_block_lock,
  output logic        o_hi_ber,
  output logic [7:0]  o_ber_count,
  output logic [15:0] o_invalid_total,
  output logic [15:0] o_slip_total
);

  import pcs_sync_pkg::*;

  localparam int unsigned SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

  lock_state_t       state, state_nxt;
  logic [SH_W-1:0]   sh_cnt, sh_nxt, sh_inc;
  logic [INV_W-1:0]  inv_cnt, inv_nxt, inv_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              hdr_bad;
  logic              hit;
  logic              slip_nxt;
  logic              lock_nxt;

  assign hdr_bad = !sh_is_valid(i_header);
  assign hit     = i_header_valid & hdr_bad;
  assign sh_inc  = sh_cnt + SH_W'(1);
  assign inv_inc = inv_cnt + INV_W'(hit);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= TEST_SH;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
    end else begin
      state        <= state_nxt;
      sh_cnt       <= sh_nxt;
      inv_cnt      <= inv_nxt;
      wait_cnt     <= wait_nxt;
      o_slip       <= slip_nxt;
      o_block_lock <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_cnt;
    inv_nxt   = inv_cnt;
    wait_nxt  = '0;
    case (state)
      TEST_SH: begin
        if (i_header_valid) begin
          if ((!o_block_lock && hdr_bad) ||
              (o_block_lock && (inv_inc == INV_W'(SH_INVALID_MAX)))) begin
            state_nxt = SLIP_WAIT;
            sh_nxt    = '0;
            inv_nxt   = '0;
          end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
            sh_nxt  = '0;
            inv_nxt = '0;
          end else begin
            sh_nxt  = sh_inc;
            inv_nxt = inv_inc;
          end
        end
      end
      SLIP_WAIT: begin
        if (wait_cnt == WAIT_W'(SLIP_WAIT_CYCLES - 1))
          state_nxt = TEST_SH;
        else
          wait_nxt = wait_cnt + WAIT_W'(1);
      end
      default: state_nxt = TEST_SH;
    endcase
  end

  // Unlocked windows only complete clean, since any bad header slips first
  always_comb begin
    slip_nxt = (state == TEST_SH) && (state_nxt == SLIP_WAIT);
    lock_nxt = o_block_lock;
    if (slip_nxt)
      lock_nxt = 1'b0;
    else if ((state == TEST_SH) && i_header_valid && !o_block_lock &&
             (sh_inc == SH_W'(SH_CNT_MAX)))
      lock_nxt = 1'b1;
  end

  pcs_ber_monitor #(
    .BER_TIMER_CYCLES (BER_TIMER_CYCLES),
    .BER_CNT_MAX      (BER_CNT_MAX)
  ) u_ber (
    .clk          (i_clk),
    .reset        (i_reset),
    .block_lock   (o_block_lock),
    .header_valid (i_header_valid),
    .sh_invalid   (hdr_bad),
    .hi_ber       (o_hi_ber),
    .ber_count    (o_ber_count)
  );

`ifdef PCS_SYNC_STATS_EN
  logic [15:0] inv_total;
  logic [15:0] slip_total;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      inv_total  <= '0;
      slip_total <= '0;
    end else if (i_stats_clear) begin
      inv_total  <= {15'd0, hit};
      slip_total <= {15'd0, slip_nxt};
    end else begin
      if (hit && (inv_total != '1))
        inv_total <= inv_total + 16'd1;
      if (slip_nxt && (slip_total != '1))
        slip_total <= slip_total + 16'd1;
    end
  end

  assign o_invalid_total = inv_total;
  assign o_slip_total    = slip_total;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = i_stats_clear;
  assign o_invalid_total    = '0;
  assign o_slip_total       = '0;
`endif

endmodule

// File: tb/tb_pcs_rx_sync_monitor.sv
// Self-checking bench for pcs_rx_sync_monitor: directed scenarios plus random
// traffic compared every cycle against a window/event-level reference model.
module tb_pcs_rx_sync_monitor;

  localparam int BER_T = 1000;

  logic        clk = 1'b0;
  logic        rst, hv, clr;
  logic [1:0]  hdr;
  logic        o_slip, o_block_lock, o_hi_ber;
  logic [7:0]  o_ber_count;
  logic [15:0] o_invalid_total, o_slip_total;

  always #5 clk = ~clk;

  pcs_rx_sync_monitor #(
    .SH_CNT_MAX       (64),
    .SH_INVALID_MAX   (16),
    .SLIP_WAIT_CYCLES (32),
    .BER_TIMER_CYCLES (BER_T),
    .BER_CNT_MAX      (16)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_header        (hdr),
    .i_header_valid  (hv),
    .i_stats_clear   (clr),
    .o_slip          (o_slip),
    .o_block_lock    (o_block_lock),
    .o_hi_ber        (o_hi_ber),
    .o_ber_count     (o_ber_count),
    .o_invalid_total (o_invalid_total),
    .o_slip_total    (o_slip_total)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  // Reference model: expected outputs after the next clock edge
  bit m_lock, m_slip, m_hi;
  int m_n, m_bad, m_ign, m_pos, m_cnt, m_inv_tot, m_slip_tot;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [1:0] h, input bit c);
    bit inv;
    bit was_lock;
    int nc;
    inv = v && !(h == 2'b01 || h == 2'b10);
    if (r) begin
      m_lock = 0; m_slip = 0; m_hi = 0; m_n = 0; m_bad = 0; m_ign = 0;
      m_pos = 0; m_cnt = 0; m_inv_tot = 0; m_slip_tot = 0;
      return;
    end
    was_lock = m_lock;
    m_slip = 0;
    if (was_lock) begin
      if (m_pos == BER_T - 1) begin
        nc    = inv ? 1 : 0;
        m_hi  = (m_cnt >= 16) || (nc >= 16);
        m_cnt = nc;
        m_pos = 0;
      end else begin
        m_pos++;
        if (inv && m_cnt < 255) m_cnt++;
        if (m_cnt >= 16) m_hi = 1;
      end
    end else begin
      m_pos = 0; m_cnt = 0; m_hi = 0;
    end
    if (m_ign > 0) begin
      m_ign--;
    end else if (v) begin
      m_n++;
      if (inv) m_bad++;
      if ((!m_lock && inv) || (m_lock && m_bad == 16)) begin
        m_lock = 0; m_slip = 1; m_ign = 32; m_n = 0; m_bad = 0;
      end else if (m_n == 64) begin
        m_lock = 1; m_n = 0; m_bad = 0;
      end
    end
    if (c) begin
      m_inv_tot  = inv ? 1 : 0;
      m_slip_tot = m_slip ? 1 : 0;
    end else begin
      if (inv && m_inv_tot < 65535) m_inv_tot++;
      if (m_slip && m_slip_tot < 65535) m_slip_tot++;
    end
  endtask

  // Drive at a falling edge, advance the model, return at the next falling edge
  task automatic step(input bit r, input bit v, input logic [1:0] h, input bit c);
    rst = r; hv = v; hdr = h; clr = c;
    model_step(r, v, h, c);
    @(negedge clk);
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("slip",       int'(o_slip),       int'(m_slip));
      chk("block_lock", int'(o_block_lock), int'(m_lock));
      chk("hi_ber",     int'(o_hi_ber),     int'(m_hi));
      chk("ber_count",  int'(o_ber_count),  m_cnt);
`ifdef PCS_SYNC_STATS_EN
      chk("invalid_total", int'(o_invalid_total), m_inv_tot);
      chk("slip_total",    int'(o_slip_total),    m_slip_tot);
`else
      chk("invalid_total_off", int'(o_invalid_total), 0);
      chk("slip_total_off",    int'(o_slip_total),    0);
`endif
    end
  end

  initial begin
    int pct;
    rst = 1'b1; hv = 1'b0; hdr = 2'b00; clr = 1'b0;
    @(negedge clk);
    checking = 1;

    // Reset state
    step(1, 0, 2'b00, 0);
    step(1, 1, 2'b11, 1);
    chk("reset_lock", int'(o_block_lock), 0);
    chk("reset_slip", int'(o_slip), 0);
    chk("reset_ber",  int'(o_ber_count), 0);

    // Lock acquisition after 64 clean headers
    for (int i = 0; i < 64; i++) begin
      step(0, 1, good_hdr(), 0);
      if (i == 62) chk("lock_after_63", int'(o_block_lock), 0);
    end
    chk("lock_after_64", int'(o_block_lock), 1);

    // Unlocked invalid header -> slip, 32 ignored clocks, then 64 clean
    step(1, 0, 2'b00, 0);
    for (int i = 0; i < 9; i++) step(0, 1, good_hdr(), 0);
    step(0, 1, 2'b00, 0);
    chk("unlocked_slip", int'(o_slip), 1);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 2'b00, 0);
      if (i == 0) chk("slip_one_cycle", int'(o_slip), 0);
    end
    for (int i = 0; i < 64; i++) begin
      step(0, 1, good_hdr(), 0);
      if (i == 62) chk("relock_63", int'(o_block_lock), 0);
    end
    chk("relock_64", int'(o_block_lock), 1);

    // Locked: 15 invalid per window holds lock, 16 drops it
    for (int k = 0; k < 64; k++)
      step(0, 1, (k % 4 == 1 && k < 60) ? 2'b11 : good_hdr(), 0);
    chk("hold_15_bad", int'(o_block_lock), 1);
    for (int k = 0; k < 10; k++) step(0, 1, good_hdr(), 0);
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 2'b11, 0);
      if (k == 14) chk("lock_at_15th", int'(o_block_lock), 1);
    end
    chk("loss_lock", int'(o_block_lock), 0);
    chk("loss_slip", int'(o_slip), 1);

    // hi_ber across two BER windows
    for (int i = 0; i < 32 + 64; i++) step(0, 1, good_hdr(), 0);
    chk("ber_lock", int'(o_block_lock), 1);
    for (int j = 0; j < 2 * BER_T; j++) begin
      bit b;
      b = (j < BER_T) ? (j % 32 == 0) : (j == 1100 || j == 1200 || j == 1300);
      step(0, 1, b ? bad_hdr() : good_hdr(), 0);
      if (j == BER_T - 1) begin
        chk("hi_ber_win1", int'(o_hi_ber), 1);
        chk("ber_cnt_wrap1", int'(o_ber_count), 0);
      end
      if (j == 2 * BER_T - 2) begin
        chk("ber_cnt_win2", int'(o_ber_count), 3);
        chk("hi_ber_hold", int'(o_hi_ber), 1);
      end
    end
    chk("hi_ber_clear", int'(o_hi_ber), 0);

    // Gapped validity: invalid headers on unqualified cycles have no effect
    step(1, 0, 2'b00, 0);
    for (int q = 0; q < 64; q++) begin
      step(0, 1, good_hdr(), 0);
      if (q == 62) chk("gap_lock_63", int'(o_block_lock), 0);
      if (q == 63) chk("gap_lock_64", int'(o_block_lock), 1);
      step(0, 0, bad_hdr(), 0);
    end

    // Reset during SLIP_WAIT
    step(1, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, good_hdr(), 0);
    step(0, 1, 2'b00, 0);
`ifdef PCS_SYNC_STATS_EN
    chk("stats_slip_1", int'(o_slip_total), 1);
`endif
    for (int i = 0; i < 5; i++) step(0, 1, bad_hdr(), 0);
    step(1, 1, 2'b00, 0);
    chk("rst_mid_lock", int'(o_block_lock), 0);
    chk("rst_mid_slip", int'(o_slip), 0);
    chk("rst_mid_tot", int'(o_invalid_total) + int'(o_slip_total), 0);
    for (int i = 0; i < 64; i++) step(0, 1, good_hdr(), 0);
    chk("rst_relock", int'(o_block_lock), 1);

    // Statistics clear with a coincident invalid header
    step(1, 0, 2'b00, 0);
    step(0, 1, 2'b00, 0);
    for (int i = 0; i < 3; i++) step(0, 1, bad_hdr(), 0);
    step(0, 1, 2'b11, 1);
`ifdef PCS_SYNC_STATS_EN
    chk("clr_inv_1", int'(o_invalid_total), 1);
    chk("clr_slip_0", int'(o_slip_total), 0);
`endif

    // Randomised traffic with varying error density
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: pct = 0;
        1: pct = 2;
        2: pct = 10;
        default: pct = 30;
      endcase
      for (int i = 0; i < 500; i++) begin
        bit r, v, c;
        r = ($urandom_range(0, 999) == 0);
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 99) == 0);
        step(r, v, ($urandom_range(0, 99) < pct) ? bad_hdr() : good_hdr(), c);
      end
    end

    step(0, 0, 2'b00, 0);
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcs_rx_sync_monitor.md
Name: pcs_rx_sync_monitor

Overview:
Parametrised receive block-sync and bit-error-rate monitor for the 64b/66b PCS receive path. It sits after the rx gearbox (internal or external) and before descrambler/decoder. It acquires and holds block lock from the 2-bit sync headers and drives gearbox slip. It adds a BER monitor with hi_ber indication, plus configurable lock thresholds and slip settle time for 32- and 64-bit datapaths.

Parameters:
SH_CNT_MAX, 64, number of headers per test window.
SH_INVALID_MAX, 16, invalid headers within a locked window that force loss of lock.
SLIP_WAIT_CYCLES, 32, clocks after a slip during which headers are ignored (gearbox settle).
BER_TIMER_CYCLES, 40283, BER window length in clocks (125 us at 322.27 MHz).
BER_CNT_MAX, 16, invalid headers in one BER window that assert hi_ber.

Ports:
i_clk  in  1  receive clock (xver_rx_clk domain).
i_reset  in  1  synchronous, active-high reset.
i_header  in  2  sync header from gearbox.
i_header_valid  in  1  i_header qualifier.
i_stats_clear  in  1  clears statistics counters (used only with the optional feature).
o_slip  out  1  one-cycle gearbox slip pulse.
o_block_lock  out  1  block lock status.
o_hi_ber  out  1  high bit-error-rate indication.
o_ber_count  out  8  invalid headers in the current BER window, saturating at 255.
o_invalid_total  out  16  optional statistics: total invalid headers.
o_slip_total  out  16  optional statistics: total slips.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; all counters 0; FSM in TEST_SH.
- Header classification: a header is valid only when i_header is 2'b01 or 2'b10. Headers 00 and 11 are invalid. Only cycles with i_header_valid=1 are counted.
- Lock FSM, states TEST_SH and SLIP_WAIT. Counters sh_cnt and inv_cnt are sized with $clog2.
- TEST_SH, per valid-qualified header: sh_cnt increments, and inv_cnt increments on an invalid header.
  - Unlocked, invalid header: go to SLIP_WAIT.
  - Unlocked, sh_cnt reaches SH_CNT_MAX with inv_cnt=0: o_block_lock=1 from the next cycle; counters restart. No header is dropped: the counter restart and the next header's count happen in the same cycle.
  - Locked, inv_cnt reaches SH_INVALID_MAX: o_block_lock=0 and go to SLIP_WAIT immediately, even mid-window.
  - Locked, sh_cnt reaches SH_CNT_MAX with inv_cnt<SH_INVALID_MAX: counters restart and lock is held.
- Entering SLIP_WAIT: o_slip=1 for exactly that transition cycle. Registered output, asserted the cycle after the offending header.
- SLIP_WAIT: i_header is ignored for SLIP_WAIT_CYCLES clocks. Then return to TEST_SH with counters cleared.
- BER monitor: active only while o_block_lock=1.
  - Free-running window timer, 0..BER_TIMER_CYCLES-1.
  - Each invalid header increments ber_cnt (saturating).
  - ber_cnt reaching BER_CNT_MAX sets o_hi_ber=1 on the next cycle.
  - At timer wrap: if ber_cnt<BER_CNT_MAX, o_hi_ber clears; ber_cnt resets to 0.
  - An invalid header on the wrap cycle counts into the new window (ber_cnt=1).
  - While unlocked: timer, ber_cnt and o_hi_ber are held at 0.
- o_ber_count mirrors ber_cnt, clamped to 255.
- Reset mid-operation: reset overrides everything within one cycle. No slip is issued on the reset cycle.

Optional Feature:
PCS_SYNC_STATS_EN
- Defined: o_invalid_total counts every valid-qualified invalid header, lock state irrelevant. o_slip_total counts o_slip pulses. Both 16-bit and saturating at 16'hFFFF. i_stats_clear zeroes both; an event coinciding with the clear yields count 1.
- Undefined: both outputs tied 0, i_stats_clear ignored, no counter logic synthesised.

Decomposition:
- Shared package pcs_sync_pkg:
  - SH_DATA=2'b01 and SH_CTRL=2'b10.
  - lock_state_t enum {TEST_SH, SLIP_WAIT}.
  - Function sh_is_valid().
- Sub-module pcs_ber_monitor (timer, ber_cnt, hi_ber), instantiated once. Its inputs are block_lock, header_valid and sh_invalid.

Test Plan:
- Lock acquisition: reset, then 64 consecutive valid headers (01/10) -> o_block_lock=1 one cycle after the 64th; o_slip never pulses.
- Unlocked invalid header: invalid header 00 at header 10 while unlocked -> one o_slip pulse next cycle. The following 32 clocks of headers are ignored; lock then takes 64 clean headers.
- Lock loss: when locked, inject 16 headers of 11 within one 64-header window -> o_block_lock falls and o_slip pulses on the cycle after the 16th. With 15 invalid headers, lock is held.
- hi_ber: with BER_TIMER_CYCLES=1000, 16 invalid headers inside one window -> o_hi_ber=1. A following window with 3 invalid headers -> o_hi_ber=0 at the second wrap; o_ber_count reads 3 before that wrap.
- Gapped validity: i_header_valid at 50% duty, with invalid headers on gap cycles -> no effect; lock after 64 qualified headers.
- Reset mid-SLIP_WAIT: assert i_reset during SLIP_WAIT -> all outputs 0 next cycle; re-lock after 64 clean headers. With PCS_SYNC_STATS_EN: o_slip_total=1 before reset, and 0 after reset or i_stats_clear.
